// File: rtl/rec_id_access_arb_if.sv
// Bus bundle for the receive-ID register arbiter: capture inputs, CPU write port,
// and the strobe/data lines that fan out to the two 16-bit arbitration registers.
interface rec_id_access_arb_if #(
  parameter int REGW = 16,
  parameter int IDW  = 29
);
  logic            prom;
  logic            can_cap;
  logic [IDW-1:0]  can_id;
  logic            can_ide;
  logic            cpu_req;
  logic            cpu_addr;
  logic [REGW-1:0] cpu_data;
  logic            ovr_clr;
  logic            reg1_cpu;
  logic            reg2_cpu;
  logic            reg1_can;
  logic            reg2_can;
  logic [REGW-1:0] reginp;
  logic [REGW-1:0] recidin;
  logic            cpu_ack;
  logic            busy;
  logic            ovr;

  modport master (
    output prom, can_cap, can_id, can_ide, cpu_req, cpu_addr, cpu_data, ovr_clr,
    input  reg1_cpu, reg2_cpu, reg1_can, reg2_can, reginp, recidin, cpu_ack, busy, ovr
  );

  modport slave (
    input  prom, can_cap, can_id, can_ide, cpu_req, cpu_addr, cpu_data, ovr_clr,
    output reg1_cpu, reg2_cpu, reg1_can, reg2_can, reginp, recidin, cpu_ack, busy, ovr
  );
endinterface

// File: rtl/rec_id_access_arb.sv
// Shares reg1/reg2 between CPU writes and promiscuous-mode ID captures (hi word, then lo word).
// Define RECARB_ATOMIC_EN to route CPU writes through the sequencer with round-robin arbitration.
module rec_id_access_arb #(
  parameter int REGW = 16,
  parameter int IDW  = 29
) (
  input logic                clk,
  input logic                rst,
  rec_id_access_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CAN_HI, CAN_LO, CPU_WR} state_e;

  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  logic [IDW:0]    buf_q, buf_d;
  logic [IDW:0]    work_q, work_d;
  logic            ovr_q, ovr_d;
  logic            busy_q, busy_d;
  logic            reg1_cpu_q, reg1_cpu_d;
  logic            reg2_cpu_q, reg2_cpu_d;
  logic            reg1_can_q, reg1_can_d;
  logic            reg2_can_q, reg2_can_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic [REGW-1:0] reginp_q, reginp_d;
  logic [REGW-1:0] recidin_q, recidin_d;
  logic            can_rdy, cpu_rdy, consume;
`ifdef RECARB_ATOMIC_EN
  logic            prio_cpu_q, prio_cpu_d;
`endif

  // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    buf_d      = buf_q;
    work_d     = work_q;
    ovr_d      = ovr_q;
    reg1_cpu_d = 1'b0;
    reg2_cpu_d = 1'b0;
    reg1_can_d = 1'b0;
    reg2_can_d = 1'b0;
    cpu_ack_d  = 1'b0;
    reginp_d   = reginp_q;
    recidin_d  = recidin_q;
    consume    = 1'b0;
`ifdef RECARB_ATOMIC_EN
    prio_cpu_d = prio_cpu_q;
`endif
    can_rdy = pend_q && bus.prom;
    // A request still high in the ack cycle belongs to the write just done.
    cpu_rdy = bus.cpu_req && !cpu_ack_q;

    case (state_q)
      IDLE: begin
`ifdef RECARB_ATOMIC_EN
        if (cpu_rdy && (!can_rdy || prio_cpu_q)) begin
          state_d    = CPU_WR;
          prio_cpu_d = 1'b0;
          reg1_cpu_d = !bus.cpu_addr;
          reg2_cpu_d = bus.cpu_addr;
          reginp_d   = bus.cpu_data;
          cpu_ack_d  = 1'b1;
        end else if (can_rdy) begin
          prio_cpu_d = 1'b1;
          consume    = 1'b1;
        end
`else
        consume = can_rdy;
`endif
        if (consume) begin
          state_d    = CAN_HI;
          work_d     = buf_q;
          reg2_can_d = 1'b1;
          recidin_d  = {buf_q[IDW], 2'b00, buf_q[IDW-1:16]};
        end
      end
      CAN_HI: begin
        state_d    = CAN_LO;
        reg1_can_d = 1'b1;
        recidin_d  = work_q[15:0];
      end
      CAN_LO:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef RECARB_ATOMIC_EN
`else
    // CPU path bypasses the sequencer; the register resolves any collision itself.
    if (cpu_rdy) begin
      reg1_cpu_d = !bus.cpu_addr;
      reg2_cpu_d = bus.cpu_addr;
      reginp_d   = bus.cpu_data;
      cpu_ack_d  = 1'b1;
    end
`endif

    if (consume) pend_d = 1'b0;
    if (!bus.prom) begin
      pend_d = 1'b0;
    end else if (bus.can_cap) begin
      // Overwriting a pending ID that the sequencer did not take this cycle is an overrun.
      if (pend_q && !consume) ovr_d = 1'b1;
      pend_d = 1'b1;
      buf_d  = {bus.can_ide, bus.can_id};
    end
    if (bus.ovr_clr) ovr_d = 1'b0;

    busy_d = (state_d == CAN_HI) || (state_d == CAN_LO);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      buf_q      <= '0;
      work_q     <= '0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
      reg1_cpu_q <= 1'b0;
      reg2_cpu_q <= 1'b0;
      reg1_can_q <= 1'b0;
      reg2_can_q <= 1'b0;
      cpu_ack_q  <= 1'b0;
      reginp_q   <= '0;
      recidin_q  <= '0;
`ifdef RECARB_ATOMIC_EN
      prio_cpu_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      buf_q      <= buf_d;
      work_q     <= work_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
      reg1_cpu_q <= reg1_cpu_d;
      reg2_cpu_q <= reg2_cpu_d;
      reg1_can_q <= reg1_can_d;
      reg2_can_q <= reg2_can_d;
      cpu_ack_q  <= cpu_ack_d;
      reginp_q   <= reginp_d;
      recidin_q  <= recidin_d;
`ifdef RECARB_ATOMIC_EN
      prio_cpu_q <= prio_cpu_d;
`endif
    end
  end

  assign bus.reg1_cpu = reg1_cpu_q;
  assign bus.reg2_cpu = reg2_cpu_q;
  assign bus.reg1_can = reg1_can_q;
  assign bus.reg2_can = reg2_can_q;
  assign bus.reginp   = reginp_q;
  assign bus.recidin  = recidin_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.busy     = busy_q;
  assign bus.ovr      = ovr_q;
endmodule

// File: tb/tb_rec_id_access_arb.sv
// Scoreboard bench for rec_id_access_arb: a cycle-stamped transaction model predicts every
// register write, busy and ovr; a negedge monitor pops and compares what the DUT presents.
module tb_rec_id_access_arb;
  localparam int MAXC = 4096;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [1:0]  sel;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  rec_id_access_arb_if bus ();

  rec_id_access_arb dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  bit  done = 1'b0;
  ev_t hi_q[$];
  ev_t lo_q[$];
  ev_t cpu_q[$];
  bit  exp_busy[MAXC];
  bit  exp_ovr[MAXC];
  bit  zero_chk[MAXC];

  // Reference model state: pending capture, when the sequencer is free again, arbitration history.
  bit          m_pend, m_ovr, m_prio_cpu, m_ide;
  logic [28:0] m_id;
  int          m_idle_from, m_last_ack;
  bit          cpu_active;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic purge(input int c);
    while (hi_q.size() > 0 && hi_q[$].cyc > c) void'(hi_q.pop_back());
    while (lo_q.size() > 0 && lo_q[$].cyc > c) void'(lo_q.pop_back());
    while (cpu_q.size() > 0 && cpu_q[$].cyc > c) void'(cpu_q.pop_back());
  endtask

  // Predicts the effect of this cycle's inputs (sampled at the coming edge).
  task automatic model_step();
    int c = cyc;
    bit idle, can_rdy, cpu_rdy, g_can, g_cpu;
    if (rst) begin
      purge(c);
      m_pend = 0; m_ovr = 0; m_prio_cpu = 1; m_idle_from = c + 1; m_last_ack = -1;
      exp_busy[c+1] = 0; exp_busy[c+2] = 0; exp_ovr[c+1] = 0; zero_chk[c+1] = 1;
      return;
    end
    idle    = (c >= m_idle_from);
    can_rdy = m_pend && bus.prom;
    cpu_rdy = bus.cpu_req && (m_last_ack != c);
    g_can = 0; g_cpu = 0;
`ifdef RECARB_ATOMIC_EN
    if (idle && cpu_rdy && (!can_rdy || m_prio_cpu)) g_cpu = 1;
    else if (idle && can_rdy) g_can = 1;
`else
    g_cpu = cpu_rdy;
    g_can = idle && can_rdy;
`endif
    if (g_cpu) begin
      cpu_q.push_back('{c + 1, bus.cpu_data, bus.cpu_addr ? 2'b10 : 2'b01});
      m_last_ack = c + 1;
`ifdef RECARB_ATOMIC_EN
      m_idle_from = c + 2;
      m_prio_cpu = 0;
`endif
    end
    if (g_can) begin
      hi_q.push_back('{c + 1, 16'((int'(m_ide) << 15) | (int'(m_id) >> 16)), 2'b00});
      lo_q.push_back('{c + 2, 16'(int'(m_id) % 65536), 2'b00});
      exp_busy[c+1] = 1; exp_busy[c+2] = 1;
      m_idle_from = c + 3;
      m_prio_cpu = 1;
    end
    if (!bus.prom) m_pend = 0;
    else if (bus.can_cap) begin
      if (m_pend && !g_can) m_ovr = 1;
      m_pend = 1; m_id = bus.can_id; m_ide = bus.can_ide;
    end else if (g_can) m_pend = 0;
    if (bus.ovr_clr) m_ovr = 0;
    exp_ovr[c+1] = m_ovr;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    bus.can_cap = 0; bus.ovr_clr = 0; rst = 0;
    if (cpu_active && m_last_ack >= 0 && cyc == m_last_ack + 1) begin
      cpu_active = 0; bus.cpu_req = 0;
    end
  endtask

  task automatic idle_n(input int n);
    repeat (n) step();
  endtask

  task automatic cap(input logic [28:0] id, input bit ide);
    bus.can_cap = 1; bus.can_id = id; bus.can_ide = ide;
    step();
  endtask

  task automatic cpu(input bit addr, input logic [15:0] data);
    if (!cpu_active) begin
      cpu_active = 1; bus.cpu_req = 1; bus.cpu_addr = addr; bus.cpu_data = data;
    end
  endtask

  // Monitor: compares what the DUT presents against the scoreboard, mid-cycle.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC && !done) begin
      ev_t e;
      while (hi_q.size() > 0 && hi_q[0].cyc < cyc) begin e = hi_q.pop_front(); check("can_hi_missing", cyc, e.cyc); end
      while (lo_q.size() > 0 && lo_q[0].cyc < cyc) begin e = lo_q.pop_front(); check("can_lo_missing", cyc, e.cyc); end
      while (cpu_q.size() > 0 && cpu_q[0].cyc < cyc) begin e = cpu_q.pop_front(); check("cpu_missing", cyc, e.cyc); end
      if (bus.reg2_can) begin
        if (hi_q.size() == 0) check("can_hi_unexpected", bus.reg2_can, 0);
        else begin e = hi_q.pop_front(); check("can_hi_cycle", cyc, e.cyc); check("can_hi_word", bus.recidin, e.data); end
      end
      if (bus.reg1_can) begin
        if (lo_q.size() == 0) check("can_lo_unexpected", bus.reg1_can, 0);
        else begin e = lo_q.pop_front(); check("can_lo_cycle", cyc, e.cyc); check("can_lo_word", bus.recidin, e.data); end
      end
      if (bus.cpu_ack) begin
        if (cpu_q.size() == 0) check("cpu_ack_unexpected", bus.cpu_ack, 0);
        else begin
          e = cpu_q.pop_front();
          check("cpu_cycle", cyc, e.cyc);
          check("cpu_strobe", {bus.reg2_cpu, bus.reg1_cpu}, e.sel);
          check("cpu_reginp", bus.reginp, e.data);
        end
      end else check("cpu_strobe_without_ack", {bus.reg2_cpu, bus.reg1_cpu}, 0);
      check("busy", bus.busy, exp_busy[cyc]);
      check("ovr", bus.ovr, exp_ovr[cyc]);
      if (zero_chk[cyc])
        check("reset_outputs", {bus.reg1_cpu, bus.reg2_cpu, bus.reg1_can, bus.reg2_can,
                                bus.reginp, bus.recidin, bus.cpu_ack, bus.busy, bus.ovr}, 0);
    end
  end

  initial begin
    rst = 1;
    bus.prom = 1; bus.can_cap = 0; bus.can_id = '0; bus.can_ide = 0;
    bus.cpu_req = 0; bus.cpu_addr = 0; bus.cpu_data = '0; bus.ovr_clr = 0;
    cpu_active = 0; m_pend = 0; m_ovr = 0; m_prio_cpu = 1; m_idle_from = 0; m_last_ack = -1;
    m_id = '0; m_ide = 0;
    rst = 1; step();
    rst = 1; step();
    idle_n(2);

    // Extended capture split into hi/lo words.
    cap(29'h1ABC_DEF0, 1'b1); idle_n(6);
    // Single CPU write with request held into the ack cycle.
    cpu(1'b1, 16'h5A5A); idle_n(5);
    // Three back-to-back captures: second lost, ovr set, then cleared.
    cap(29'h0123_4567, 1'b0); cap(29'h0765_4321, 1'b1); cap(29'h1FFF_FFFF, 1'b1);
    idle_n(6); bus.ovr_clr = 1; step(); idle_n(3);
    // CPU request arriving while the hi word is being written.
    cap(29'h1555_AAAA, 1'b0); idle_n(1); cpu(1'b0, 16'hC3C3); idle_n(8);
    // CPU request and pending capture together in IDLE, twice.
    cap(29'h0AAA_5555, 1'b1); cpu(1'b0, 16'h1111); idle_n(8);
    cap(29'h0BBB_6666, 1'b0); cpu(1'b1, 16'h2222); idle_n(8);
    // Reset during the hi-word write, then a capture dropped by prom going low.
    cap(29'h1234_5678, 1'b1); idle_n(1); rst = 1; step(); idle_n(3);
    cap(29'h0FED_CBA9, 1'b0); bus.prom = 0; idle_n(4); bus.prom = 1; idle_n(2);

    for (int i = 0; i < 1500; i++) begin
      bus.prom    = ($urandom_range(15) != 0);
      bus.can_cap = ($urandom_range(3) == 0);
      bus.can_id  = 29'($urandom);
      bus.can_ide = 1'($urandom);
      bus.ovr_clr = ($urandom_range(19) == 0);
      rst         = ($urandom_range(199) == 0);
      if (!cpu_active && $urandom_range(4) == 0) cpu(1'($urandom), 16'($urandom));
      step();
    end

    bus.prom = 1;
    idle_n(12);
    check("hi_q_left", hi_q.size(), 0);
    check("lo_q_left", lo_q.size(), 0);
    check("cpu_q_left", cpu_q.size(), 0);
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
